// File: rtl/mar_burst.sv
// Memory address register with a direct-load path and a strided
// burst engine that walks LEN addresses under a req/ack handshake.
module mar_burst #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 4,
  parameter int STRIDE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mar_in,
  input  logic [ADDR_W-1:0] address,
  input  logic              burst_start,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic              abort,
  input  logic              ram_ack,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_req,
  output logic              busy,
  output logic              done,
  output logic              wrapped
);

  typedef enum logic {
    IDLE,
    BURST
  } state_e;

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(STRIDE);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  rem_q;
  logic              req_q;
  logic              done_q;
  logic              wrap_q;
  logic [ADDR_W:0]   sum;

  // Extra top bit captures the carry that marks a wrap.
  assign sum = {1'b0, addr_q} + {1'b0, STEP};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (burst_start) begin
            addr_q <= address;
            if (burst_len != '0) begin
              rem_q   <= burst_len;
              wrap_q  <= 1'b0;
              req_q   <= 1'b1;
              state_q <= BURST;
            end else begin
              done_q <= 1'b1;
            end
          end else if (mar_in) begin
            addr_q <= address;
          end
        end
        BURST: begin
          unique case (1'b1)
            abort: begin
              state_q <= IDLE;
              req_q   <= 1'b0;
              rem_q   <= '0;
            end
            (!abort && ram_ack && rem_q == LEN_W'(1)): begin
              state_q <= IDLE;
              req_q   <= 1'b0;
              rem_q   <= '0;
              done_q  <= 1'b1;
            end
            (!abort && ram_ack && rem_q != LEN_W'(1)): begin
              addr_q <= sum[ADDR_W-1:0];
              rem_q  <= rem_q - LEN_W'(1);
              if (sum[ADDR_W]) wrap_q <= 1'b1;
            end
            default: ;
          endcase
        end
      endcase
    end
  end

  assign ram_address = addr_q;
  assign ram_req     = req_q;
  assign busy        = req_q;
  assign done        = done_q;
  assign wrapped     = wrap_q;

endmodule

// File: tb/tb_mar_burst.sv
// Scoreboard bench for mar_burst: expected beat addresses are queued
// at burst start and popped as the RAM accepts each beat.
module tb_mar_burst;

  logic       clk = 1'b0;
  logic       rst;
  logic       mar_in;
  logic [7:0] address;
  logic       burst_start;
  logic [3:0] burst_len;
  logic       abort;
  logic       ram_ack;
  logic [7:0] ram_address;
  logic       ram_req;
  logic       busy;
  logic       done;
  logic       wrapped;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_a;

  mar_burst dut (
    .clk(clk), .rst(rst), .mar_in(mar_in), .address(address),
    .burst_start(burst_start), .burst_len(burst_len), .abort(abort),
    .ram_ack(ram_ack), .ram_address(ram_address), .ram_req(ram_req),
    .busy(busy), .done(done), .wrapped(wrapped)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input logic [7:0] a, input logic [3:0] n);
    burst_start = 1'b1;
    address     = a;
    burst_len   = n;
    for (int i = 0; i < n; i++) exp_q.push_back(a + 8'(i));
    tick();
    burst_start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; mar_in = 1'b1; address = 8'h3C;
    burst_start = 1'b0; burst_len = 4'd0; abort = 1'b0; ram_ack = 1'b0;
    tick();
    checks++;
    if ({ram_address, ram_req, busy, done, wrapped} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outs: got addr=%h req=%b busy=%b done=%b wrap=%b want all 0",
               ram_address, ram_req, busy, done, wrapped);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (ram_address !== 8'h3C || ram_req !== 1'b0) begin
      errors++;
      $display("FAIL legacy_load: got addr=%h req=%b want 3c/0", ram_address, ram_req);
    end
    mar_in = 1'b0;
  endtask

  task automatic test_basic_burst;
    int busy_n = 0;
    int done_n = 0;
    start_burst(8'h10, 4'd4);
    ram_ack = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (busy) busy_n++;
      if (done) done_n++;
      if (ram_req && ram_ack) begin
        exp_a = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (ram_address !== exp_a) begin
          errors++;
          $display("FAIL basic_addr: got %h want %h", ram_address, exp_a);
        end
      end
      tick();
    end
    ram_ack = 1'b0;
    checks++;
    if (busy_n != 4 || done_n != 1 || ram_address !== 8'h13 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL basic_summary: busy=%0d done=%0d addr=%h left=%0d want 4/1/13/0",
               busy_n, done_n, ram_address, exp_q.size());
    end
  endtask

  task automatic test_wait_wrap;
    logic wrap_at_ff = 1'b1;
    start_burst(8'hFE, 4'd3);
    for (int c = 0; c < 12; c++) begin
      ram_ack = c[0];
      if (ram_req) begin
        if (ram_address === 8'hFF) wrap_at_ff = wrapped;
        exp_a = (exp_q.size() != 0) ? exp_q[0] : 8'hxx;
        checks++;
        if (ram_address !== exp_a) begin
          errors++;
          $display("FAIL wait_addr: got %h want %h", ram_address, exp_a);
        end
        if (ram_ack && exp_q.size() != 0) void'(exp_q.pop_front());
      end
      tick();
    end
    ram_ack = 1'b0;
    checks++;
    if (wrapped !== 1'b1 || wrap_at_ff !== 1'b0 || ram_address !== 8'h00 ||
        exp_q.size() != 0) begin
      errors++;
      $display("FAIL wrap_flag: wrapped=%b early=%b addr=%h left=%0d want 1/0/00/0",
               wrapped, wrap_at_ff, ram_address, exp_q.size());
    end
  endtask

  task automatic test_abort;
    start_burst(8'h20, 4'd8);
    ram_ack = 1'b1;
    for (int b = 0; b < 3; b++) begin
      exp_a = exp_q.pop_front();
      checks++;
      if (ram_address !== exp_a || ram_req !== 1'b1) begin
        errors++;
        $display("FAIL abort_beat: got %h req=%b want %h/1", ram_address, ram_req, exp_a);
      end
      if (b == 2) abort = 1'b1;
      tick();
    end
    abort = 1'b0;
    ram_ack = 1'b0;
    exp_q.delete();
    checks++;
    if (ram_address !== 8'h22 || ram_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_stop: addr=%h req=%b busy=%b done=%b want 22/0/0/0",
               ram_address, ram_req, busy, done);
    end
    tick();
    checks++;
    if (done !== 1'b0 || ram_address !== 8'h22) begin
      errors++;
      $display("FAIL abort_nodone: done=%b addr=%h want 0/22", done, ram_address);
    end
  endtask

  task automatic test_priority;
    mar_in = 1'b1;
    start_burst(8'h40, 4'd3);
    checks++;
    if (busy !== 1'b1 || ram_address !== 8'h40) begin
      errors++;
      $display("FAIL prio_start: busy=%b addr=%h want 1/40", busy, ram_address);
    end
    address = 8'h99;
    ram_ack = 1'b1;
    for (int b = 0; b < 3; b++) begin
      exp_a = exp_q.pop_front();
      checks++;
      if (ram_address !== exp_a) begin
        errors++;
        $display("FAIL prio_addr: got %h want %h", ram_address, exp_a);
      end
      tick();
    end
    mar_in = 1'b0;
    ram_ack = 1'b0;
    checks++;
    if (done !== 1'b1 || ram_address !== 8'h42) begin
      errors++;
      $display("FAIL prio_done: done=%b addr=%h want 1/42", done, ram_address);
    end
  endtask

  task automatic test_back_to_back;
    start_burst(8'h70, 4'd1);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || ram_address !== 8'h70) begin
      errors++;
      $display("FAIL b2b_start: busy=%b done=%b addr=%h want 1/0/70",
               busy, done, ram_address);
    end
    ram_ack = 1'b1;
    void'(exp_q.pop_front());
    tick();
    ram_ack = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b1 || ram_address !== 8'h70) begin
      errors++;
      $display("FAIL b2b_end: busy=%b done=%b addr=%h want 0/1/70",
               busy, done, ram_address);
    end
  endtask

  task automatic test_zero_len;
    int done_n = 0;
    int req_n = 0;
    start_burst(8'h55, 4'd0);
    for (int c = 0; c < 3; c++) begin
      if (done) done_n++;
      if (ram_req) req_n++;
      if (c == 0) begin
        checks++;
        if (ram_address !== 8'h55 || done !== 1'b1) begin
          errors++;
          $display("FAIL zero_load: addr=%h done=%b want 55/1", ram_address, done);
        end
      end
      tick();
    end
    checks++;
    if (done_n != 1 || req_n != 0) begin
      errors++;
      $display("FAIL zero_count: done=%0d req=%0d want 1/0", done_n, req_n);
    end
  endtask

  task automatic test_reset_mid;
    start_burst(8'h30, 4'd5);
    ram_ack = 1'b1;
    tick();
    checks++;
    if (ram_address !== 8'h31) begin
      errors++;
      $display("FAIL rstmid_beat2: got %h want 31", ram_address);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    checks++;
    if ({ram_address, ram_req, busy, done, wrapped} !== 12'h000) begin
      errors++;
      $display("FAIL rstmid_clear: addr=%h req=%b busy=%b done=%b wrap=%b want 0",
               ram_address, ram_req, busy, done, wrapped);
    end
    tick();
    tick();
    ram_ack = 1'b0;
    checks++;
    if (ram_address !== 8'h00 || ram_req !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_idle: addr=%h req=%b done=%b want 00/0/0",
               ram_address, ram_req, done);
    end
  endtask

  initial begin
    test_reset();
    test_basic_burst();
    test_wait_wrap();
    test_abort();
    test_priority();
    test_back_to_back();
    test_zero_len();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
